qft3_measure_unit: RTL and testbench
====================================

Name: qft3_measure_unit

Overview:
- Sits directly downstream of the 3-qubit pipelined QFT top.
- Consumes the 8 final complex amplitudes f000..f111 plus a latency-matched valid tag, and computes per-basis-state probability |a|^2 in fixed point.
- Finds the most probable basis state and presents results to a consumer over a valid/ready interface.
- A 2-entry output buffer absorbs backpressure. The upstream QFT cannot stall, so samples that overflow the buffer are dropped and flagged.

Parameters:
- TOTAL_WIDTH, `TOTAL_WIDTH (fixed_point_params.vh): signed amplitude width.
- FRAC_WIDTH, `FRAC_WIDTH (fixed_point_params.vh): fractional bits; 1.0 = 2^FRAC_WIDTH.
- PROB_WIDTH, TOTAL_WIDTH: unsigned probability width, same Q format as amplitudes minus sign.
- NORM_TOL, 64: allowed |sum(prob) - 1.0| in LSBs. Used only with the optional feature.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  amplitude bus valid this cycle; no ready, upstream is free-running.
- amp_in  in  16*TOTAL_WIDTH  packed {f111_i,f111_r,...,f000_i,f000_r}; f000_r at LSBs.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts result when out_valid&&out_ready.
- prob_out  out  8*PROB_WIDTH  packed prob[7..0], prob[0] at LSBs.
- max_idx  out  3  index of largest prob; lowest index wins ties.
- max_prob  out  PROB_WIDTH  prob[max_idx].
- overflow  out  1  sticky; set when a result is dropped, cleared only by reset.
- norm_err  out  1  present only with QFT3_MEAS_NORM_CHECK_EN.

Behaviour:
- Interface: one clock clk; reset rst_n is asynchronous, active-low.
- Reset: all pipeline valids 0, buffer empty; out_valid=0, prob_out=0, max_idx=0, max_prob=0, overflow=0, norm_err=0.
- P1: register sq_r=r*r and sq_i=i*i, each 2*TOTAL_WIDTH signed, always non-negative.
- P2: prob = (sq_r>>FRAC_WIDTH)+(sq_i>>FRAC_WIDTH), truncating. Saturate to 2^PROB_WIDTH-1 if it exceeds that.
- P3: compare pairs (0,1),(2,3),(4,5),(6,7); keep {idx,value}; lower idx on equal.
- P4: two further compare levels to the final max, same tie rule. Result written to buffer.
- Latency: in_valid at cycle N gives a buffer write at edge N+4. out_valid is asserted at N+4 when the buffer was empty.
- Pipeline never stalls; valid bits travel with the data; non-valid slots write nothing.
- Output buffer: 2-entry FIFO; head drives prob_out/max_idx/max_prob.
  - Pop on out_valid&&out_ready.
  - Simultaneous push and pop when full: both take effect, no drop.
  - Push while full without pop: new result dropped, overflow<=1, buffer contents unchanged.
- Outputs are stable while out_valid&&!out_ready.
- Reset mid-operation: in-flight samples are discarded, buffer empties immediately, and no output is produced after deassertion until fresh inputs arrive.
- Back-to-back in_valid is supported at full rate.

Optional Feature:
- Macro QFT3_MEAS_NORM_CHECK_EN.
- When defined:
  - A P3 adder sums the 8 probs at PROB_WIDTH+3 bits.
  - norm_err is stored in the buffer entry alongside the result. It is 1 when |sum - 2^FRAC_WIDTH| > NORM_TOL.
  - Adds one norm_err port; latency unchanged.
- When undefined: no adder, no port, no extra storage.

Decomposition:
- Shared header fixed_point_params.vh supplies TOTAL_WIDTH, FRAC_WIDTH, and a FP_ONE constant.
- Add PROB_WIDTH and the basis-index width (3) there for reuse by later n-qubit measure blocks.
- One natural sub-module: qft_prob_calc, a single complex amplitude to saturated probability (P1–P2).
- Instantiate qft_prob_calc 8 times.
- Comparator tree and FIFO stay in the top.

Test Plan:
- Bench uses TOTAL_WIDTH=16, FRAC_WIDTH=14, out_ready=1.
- Basis state: f011_r=16384, all others 0, in_valid 1 cycle → 4 cycles later out_valid=1, prob[3]=16384, others 0, max_idx=3, max_prob=16384.
- Uniform: all 8 real parts 5793, imag 0 → every prob=2048, max_idx=0 (tie rule). With norm check enabled: sum=16384, norm_err=0.
- Negative/imag: f101_i=-16384, others 0 → prob[5]=16384, max_idx=5. Tie f010_r=f110_r=11585 → prob[2]=prob[6]=8191, max_idx=2.
- Saturation: f100_r=f100_i=-32768 → prob[4]=65535, max_idx=4. With norm check: norm_err=1.
- Backpressure: out_ready=0, three consecutive valid samples A,B,C → A at head with stable outputs, B buffered, C dropped, overflow=1. Then out_ready=1 → A then B, out_valid falls.
- Reset: assert rst_n=0 two cycles after a valid input → out_valid stays 0 after release, overflow=0, no spurious result.

Source files
------------

// File: rtl/qft3_measure_unit_pkg.sv
// Shared fixed-point and measurement types for the QFT measure blocks.
// Fixed-point format, probability width and basis-index width live here for reuse by n-qubit variants.
package qft3_measure_unit_pkg;

  localparam int TOTAL_WIDTH = 16;
  localparam int FRAC_WIDTH  = 14;
  localparam int FP_ONE      = 1 << FRAC_WIDTH;
  localparam int PROB_WIDTH  = TOTAL_WIDTH;
  localparam int IDX_WIDTH   = 3;
  localparam int N_BASIS     = 8;
  localparam int NORM_TOL    = 64;
  localparam int SUM_WIDTH   = PROB_WIDTH + 3;

  typedef logic [PROB_WIDTH-1:0] prob_t;

  typedef struct packed {
    logic [IDX_WIDTH-1:0] idx;
    prob_t                val;
  } cand_t;

  typedef struct packed {
    prob_t [N_BASIS-1:0]  prob;
    logic [IDX_WIDTH-1:0] idx;
    prob_t                maxp;
`ifdef QFT3_MEAS_NORM_CHECK_EN
    logic                 norm_err;
`endif
  } result_t;

  // Operand a must carry the lower index so ties resolve towards it.
  function automatic cand_t max2(input cand_t a, input cand_t b);
    return (b.val > a.val) ? b : a;
  endfunction

endpackage

// File: rtl/qft_prob_calc.sv
// One complex amplitude to saturated |a|^2 in fixed point; 2 cycles (square, then scale+sum).
// Free-running, no backpressure; valid is tracked by the instantiating block.
module qft_prob_calc
  import qft3_measure_unit_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic signed [TOTAL_WIDTH-1:0] i_re,
  input  logic signed [TOTAL_WIDTH-1:0] i_im,
  output prob_t                         o_prob
);

  logic signed [2*TOTAL_WIDTH-1:0] r_sq_r;
  logic signed [2*TOTAL_WIDTH-1:0] r_sq_i;
  logic        [2*TOTAL_WIDTH:0]   w_sum;
  prob_t                           r_prob;

  // Squares are non-negative, so the logical shift equals floor division.
  assign w_sum = {1'b0, r_sq_r >> FRAC_WIDTH} + {1'b0, r_sq_i >> FRAC_WIDTH};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq_r <= '0;
      r_sq_i <= '0;
      r_prob <= '0;
    end else begin
      r_sq_r <= i_re * i_re;
      r_sq_i <= i_im * i_im;
      r_prob <= (|w_sum[2*TOTAL_WIDTH:PROB_WIDTH]) ? '1 : w_sum[PROB_WIDTH-1:0];
    end
  end

  assign o_prob = r_prob;

endmodule

// File: rtl/qft3_measure_unit.sv
// 3-qubit measurement: per-state probability, argmax, 2-entry output buffer; in_valid to buffer write is 4 edges.
// Upstream cannot stall: pushes into a full buffer without a pop are dropped and set sticky overflow. Option: QFT3_MEAS_NORM_CHECK_EN.
module qft3_measure_unit
  import qft3_measure_unit_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [16*TOTAL_WIDTH-1:0]     amp_in,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_BASIS*PROB_WIDTH-1:0] prob_out,
  output logic [IDX_WIDTH-1:0]          max_idx,
  output logic [PROB_WIDTH-1:0]         max_prob,
`ifdef QFT3_MEAS_NORM_CHECK_EN
  output logic                          norm_err,
`endif
  output logic                          overflow
);

  logic [1:0]          r_vld;
  logic                r_p3_vld;
  prob_t               w_prob [N_BASIS];
  prob_t [N_BASIS-1:0] r_p3_prob;
  cand_t               r_pair [N_BASIS/2];
  cand_t               w_lvl_lo;
  cand_t               w_lvl_hi;
  cand_t               w_best;
  result_t             w_res;
  result_t             r_ent [2];
  logic [1:0]          r_cnt;
  logic                r_ovf;
  logic                w_push;
  logic                w_pop;

  for (genvar k = 0; k < N_BASIS; k++) begin : g_calc
    qft_prob_calc u_calc (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_re   (amp_in[(2*k)*TOTAL_WIDTH +: TOTAL_WIDTH]),
      .i_im   (amp_in[(2*k+1)*TOTAL_WIDTH +: TOTAL_WIDTH]),
      .o_prob (w_prob[k])
    );
  end

`ifdef QFT3_MEAS_NORM_CHECK_EN
  logic [SUM_WIDTH-1:0] w_sum;
  logic [SUM_WIDTH-1:0] r_sum;

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < N_BASIS; k++) w_sum = w_sum + SUM_WIDTH'(w_prob[k]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sum <= '0;
    else        r_sum <= w_sum;
  end
`endif

  // P3: first comparator level, all probabilities carried alongside.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld     <= '0;
      r_p3_vld  <= 1'b0;
      r_p3_prob <= '0;
      for (int j = 0; j < N_BASIS/2; j++) r_pair[j] <= '0;
    end else begin
      r_vld    <= {r_vld[0], in_valid};
      r_p3_vld <= r_vld[1];
      for (int k = 0; k < N_BASIS; k++) r_p3_prob[k] <= w_prob[k];
      for (int j = 0; j < N_BASIS/2; j++)
        r_pair[j] <= max2({IDX_WIDTH'(2*j), w_prob[2*j]}, {IDX_WIDTH'(2*j+1), w_prob[2*j+1]});
    end
  end

  assign w_lvl_lo = max2(r_pair[0], r_pair[1]);
  assign w_lvl_hi = max2(r_pair[2], r_pair[3]);
  assign w_best   = max2(w_lvl_lo, w_lvl_hi);

  always_comb begin
    w_res      = '0;
    w_res.prob = r_p3_prob;
    w_res.idx  = w_best.idx;
    w_res.maxp = w_best.val;
`ifdef QFT3_MEAS_NORM_CHECK_EN
    w_res.norm_err = (r_sum > SUM_WIDTH'(FP_ONE + NORM_TOL)) ||
                     (r_sum < SUM_WIDTH'(FP_ONE - NORM_TOL));
`endif
  end

  assign w_push = r_p3_vld;
  assign w_pop  = out_valid && out_ready;

  // Shift-style buffer: entry 0 is always the head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ent[0] <= '0;
      r_ent[1] <= '0;
      r_cnt    <= 2'd0;
      r_ovf    <= 1'b0;
    end else begin
      case (r_cnt)
        2'd0: begin
          if (w_push) begin
            r_ent[0] <= w_res;
            r_cnt    <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_ent[0] <= w_res;
          end else if (w_push) begin
            r_ent[1] <= w_res;
            r_cnt    <= 2'd2;
          end else if (w_pop) begin
            r_cnt    <= 2'd0;
          end
        end
        default: begin
          if (w_pop) begin
            r_ent[0] <= r_ent[1];
            if (w_push) r_ent[1] <= w_res;
            else        r_cnt    <= 2'd1;
          end else if (w_push) begin
            r_ovf <= 1'b1;
          end
        end
      endcase
    end
  end

  assign out_valid = (r_cnt != 2'd0);
  assign prob_out  = r_ent[0].prob;
  assign max_idx   = r_ent[0].idx;
  assign max_prob  = r_ent[0].maxp;
  assign overflow  = r_ovf;
`ifdef QFT3_MEAS_NORM_CHECK_EN
  assign norm_err  = r_ent[0].norm_err;
`endif

endmodule

// File: tb/tb_qft3_measure_unit.sv
// Scoreboard bench for qft3_measure_unit: a plain-arithmetic model queues expected results, a negedge monitor checks pops.
module tb_qft3_measure_unit;

  typedef struct packed {
    logic [127:0] probs;
    logic [2:0]   idx;
    logic [15:0]  maxp;
    logic         ne;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic [255:0] amp_in;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] prob_out;
  logic [2:0]   max_idx;
  logic [15:0]  max_prob;
  logic         overflow;
`ifdef QFT3_MEAS_NORM_CHECK_EN
  logic         norm_err;
`endif

  int   checks   = 0;
  int   failures = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  qft3_measure_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .amp_in    (amp_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .prob_out  (prob_out),
    .max_idx   (max_idx),
    .max_prob  (max_prob),
`ifdef QFT3_MEAS_NORM_CHECK_EN
    .norm_err  (norm_err),
`endif
    .overflow  (overflow)
  );

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // |a|^2 per basis state from integer arithmetic, then argmax with first-wins scan.
  function automatic exp_t model(input logic [255:0] b);
    exp_t   e;
    longint re, im, p, sum, best;
    e = '0; sum = 0; best = -1;
    for (int k = 0; k < 8; k++) begin
      re = longint'($signed(b[32*k +: 16]));
      im = longint'($signed(b[32*k+16 +: 16]));
      p  = (re*re)/16384 + (im*im)/16384;
      if (p > 65535) p = 65535;
      e.probs[16*k +: 16] = p[15:0];
      sum += p;
      if (p > best) begin
        best   = p;
        e.idx  = 3'(k);
        e.maxp = p[15:0];
      end
    end
    e.ne = (sum > 16384 + 64) || (sum < 16384 - 64);
    return e;
  endfunction

  function automatic logic [15:0] rnd_part();
    logic [15:0] m;
    if ($urandom_range(0, 3) == 0) return 16'($urandom);
    m = 16'($urandom_range(0, 12000));
    return ($urandom_range(0, 1) == 1) ? -m : m;
  endfunction

  // Called #1 after a rising edge; leaves the bus idle #1 after the capturing edge.
  task automatic drive(input logic [255:0] b, input bit expect_out);
    in_valid = 1'b1;
    amp_in   = b;
    if (expect_out) q.push_back(model(b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout actual=%0d_pending expected=0", q.size());
      q.delete();
    end
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL spurious_output actual=idx%0d expected=none", max_idx);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("prob_out", prob_out, e.probs);
        chk("max_idx", 128'(max_idx), 128'(e.idx));
        chk("max_prob", 128'(max_prob), 128'(e.maxp));
`ifdef QFT3_MEAS_NORM_CHECK_EN
        chk("norm_err", 128'(norm_err), 128'(e.ne));
`endif
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] b, ba;
    exp_t         ea;
    rst_n = 1'b0; in_valid = 1'b0; amp_in = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_prob_out", prob_out, 128'(0));
    chk("rst_max_idx", 128'(max_idx), 128'(0));
    chk("rst_max_prob", 128'(max_prob), 128'(0));
    chk("rst_overflow", 128'(overflow), 128'(0));
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basis state |011> with latency probe.
    b = '0; b[96 +: 16] = 16'd16384;
    drive(b, 1);
    @(posedge clk);
    @(posedge clk); #1;
    chk("latency_before", 128'(out_valid), 128'(0));
    @(posedge clk); #1;
    chk("latency_at", 128'(out_valid), 128'(1));
    drain();

    b = '0;
    for (int k = 0; k < 8; k++) b[32*k +: 16] = 16'd5793;
    drive(b, 1); drain();
    b = '0; b[32*5+16 +: 16] = 16'hC000;
    drive(b, 1); drain();
    b = '0; b[64 +: 16] = 16'd11585; b[192 +: 16] = 16'd11585;
    drive(b, 1); drain();
    b = '0; b[128 +: 16] = 16'h8000; b[144 +: 16] = 16'h8000;
    drive(b, 1); drain();

    // Random traffic at up to full rate with a ready consumer.
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        for (int k = 0; k < 16; k++) b[16*k +: 16] = rnd_part();
        drive(b, 1);
      end else begin
        @(posedge clk); #1;
      end
    end
    drain();

    // Backpressure: A held, B buffered, C dropped.
    out_ready = 1'b0;
    ba = '0; ba[96 +: 16] = 16'd16384; ba[16 +: 16] = 16'd9000;
    ea = model(ba);
    drive(ba, 1);
    b = '0; for (int k = 0; k < 8; k++) b[32*k +: 16] = 16'd5793;
    drive(b, 1);
    b = '0; b[128 +: 16] = 16'h8000;
    drive(b, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("bp_overflow", 128'(overflow), 128'(1));
    for (int i = 0; i < 3; i++) begin
      chk("bp_hold_valid", 128'(out_valid), 128'(1));
      chk("bp_hold_prob", prob_out, ea.probs);
      chk("bp_hold_idx", 128'(max_idx), 128'(ea.idx));
      chk("bp_hold_max", 128'(max_prob), 128'(ea.maxp));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain();
    chk("bp_empty_after", 128'(out_valid), 128'(0));
    chk("bp_overflow_sticky", 128'(overflow), 128'(1));

    // Reset with a sample in flight.
    b = '0; b[32 +: 16] = 16'd16384;
    drive(b, 0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_overflow", 128'(overflow), 128'(0));
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("rst_mid_no_out", 128'(out_valid), 128'(0));
      @(posedge clk); #1;
    end
    chk("rst_mid_prob", prob_out, 128'(0));

    b = '0; b[32*7 +: 16] = 16'd16384;
    drive(b, 1); drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
